// File: rtl/ro_puf_pkg.sv
// Shared types for the RO-PUF evaluation stage.
package ro_puf_pkg;

    localparam int unsigned SEL_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COUNT,
        COMPARE,
        DONE
    } state_t;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one ring-oscillator output, detects its rising edges and
// counts them with saturation while enabled.
module ro_edge_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             w_rise;
    logic [CNT_W-1:0] r_count;

    // Two-flop synchroniser followed by a history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= ro;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_prev;

    // Saturating edge counter; clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && w_rise && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/ro_puf_eval.sv
// RO-PUF evaluation stage: latches a challenge onto the two oscillator mux
// selects, waits for the muxes to settle, counts edges of both selected
// oscillators over a fixed window and reports which one ran faster.
module ro_puf_eval
    import ro_puf_pkg::*;
#(
    parameter int unsigned WINDOW     = 1024,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       challenge,
    output logic [SEL_W-1:0] sel_a,
    output logic [SEL_W-1:0] sel_b,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic             busy,
    output logic             done,
    output logic             response,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
);

    localparam int unsigned TMR_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);

    state_t           r_state;
    state_t           w_next;
    logic [TMR_W-1:0] r_tmr;
    logic [SEL_W-1:0] r_sel_a;
    logic [SEL_W-1:0] r_sel_b;
    logic             r_response;
    logic [CNT_W-1:0] r_count_a;
    logic [CNT_W-1:0] r_count_b;
    logic [CNT_W-1:0] w_cnt_a;
    logic [CNT_W-1:0] w_cnt_b;
    logic             w_accept;
    logic             w_clear;
    logic             w_enable;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus counter clear/enable decode.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_clear  = 1'b0;
        w_enable = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_clear  = 1'b1;
                    w_next   = SETTLE;
                end
            end
            SETTLE: begin
                w_clear = 1'b1;
                if (r_tmr == SETTLE_LAST) begin
                    w_next = COUNT;
                end
            end
            COUNT: begin
                w_enable = 1'b1;
                if (r_tmr == WINDOW_LAST) begin
                    w_next = COMPARE;
                end
            end
            COMPARE: w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Shared settle/window timer, restarted on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmr <= '0;
        end else if (w_next != r_state) begin
            r_tmr <= '0;
        end else if ((r_state == SETTLE) || (r_state == COUNT)) begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    // Select latching on accept and result capture in COMPARE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_a    <= '0;
            r_sel_b    <= '0;
            r_response <= 1'b0;
            r_count_a  <= '0;
            r_count_b  <= '0;
        end else if (w_accept) begin
            r_sel_a    <= challenge[2:0];
            r_sel_b    <= challenge[5:3];
            r_response <= 1'b0;
            r_count_a  <= '0;
            r_count_b  <= '0;
        end else if (r_state == COMPARE) begin
            r_response <= (w_cnt_a > w_cnt_b);
            r_count_a  <= w_cnt_a;
            r_count_b  <= w_cnt_b;
        end
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk    (clk),
        .rst    (rst),
        .ro     (ro_a),
        .clear  (w_clear),
        .enable (w_enable),
        .count  (w_cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk    (clk),
        .rst    (rst),
        .ro     (ro_b),
        .clear  (w_clear),
        .enable (w_enable),
        .count  (w_cnt_b)
    );

    assign sel_a    = r_sel_a;
    assign sel_b    = r_sel_b;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign response = r_response;
    assign count_a  = r_count_a;
    assign count_b  = r_count_b;

endmodule

// File: tb/tb_ro_puf_eval.sv
// Scoreboard bench for ro_puf_eval: stimulus pushes expected results, a
// monitor pops and compares them whenever a done pulse appears.
module tb_ro_puf_eval;

    localparam int unsigned W = 16;
    localparam int unsigned S = 4;

    typedef struct {
        string       nm;
        logic [2:0]  sa;
        logic [2:0]  sb;
        int unsigned ca;
        int unsigned cb;
        logic        resp;
        int unsigned acc;
        int unsigned lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, rst_s, start, start_s;
    logic [5:0]  challenge, challenge_s;
    logic        ro_a, ro_b;

    logic [2:0]  sel_a, sel_b, sel_a3, sel_b3, sel_a64, sel_b64;
    logic        busy, done, response;
    logic        busy3, done3, response3, busy64, done64, response64;
    logic [15:0] count_a, count_b;
    logic [2:0]  count_a3, count_b3, count_a64, count_b64;

    int unsigned cyc = 0;
    int unsigned tick = 0;
    int unsigned per_a = 4;
    int unsigned per_b = 8;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic gen(input int unsigned p, input int unsigned t);
        if (p == 0) return 1'b0;
        return ((t % p) < (p / 2));
    endfunction

    // clk-aligned square-wave oscillators, changed away from the active edge
    always @(negedge clk) begin
        tick++;
        ro_a = gen(per_a, tick);
        ro_b = gen(per_b, tick);
    end

    ro_puf_eval #(.WINDOW(W), .SETTLE_CYC(S), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge),
        .sel_a(sel_a), .sel_b(sel_b), .ro_a(ro_a), .ro_b(ro_b),
        .busy(busy), .done(done), .response(response),
        .count_a(count_a), .count_b(count_b)
    );

    ro_puf_eval #(.WINDOW(W), .SETTLE_CYC(S), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst_s), .start(start_s), .challenge(challenge_s),
        .sel_a(sel_a3), .sel_b(sel_b3), .ro_a(ro_a), .ro_b(1'b0),
        .busy(busy3), .done(done3), .response(response3),
        .count_a(count_a3), .count_b(count_b3)
    );

    ro_puf_eval #(.WINDOW(64), .SETTLE_CYC(S), .CNT_W(3)) dut64 (
        .clk(clk), .rst(rst_s), .start(start_s), .challenge(challenge_s),
        .sel_a(sel_a64), .sel_b(sel_b64), .ro_a(ro_a), .ro_b(1'b0),
        .busy(busy64), .done(done64), .response(response64),
        .count_a(count_a64), .count_b(count_b64)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    task automatic check_out(input int k, input logic [2:0] sa, input logic [2:0] sb,
                             input logic [15:0] ca, input logic [15:0] cb, input logic r);
        exp_t e;
        bit   have = 1'b0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 on dut %0d, required no done", k);
            return;
        end
        chk({e.nm, "/sel_a"},    64'(sa), 64'(e.sa));
        chk({e.nm, "/sel_b"},    64'(sb), 64'(e.sb));
        chk({e.nm, "/count_a"},  64'(ca), 64'(e.ca));
        chk({e.nm, "/count_b"},  64'(cb), 64'(e.cb));
        chk({e.nm, "/response"}, 64'(r),  64'(e.resp));
        chk({e.nm, "/latency"},  64'(cyc - e.acc + 1), 64'(e.lat));
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done)   check_out(0, sel_a,   sel_b,   count_a,          count_b,          response);
        if (done3)  check_out(1, sel_a3,  sel_b3,  {13'b0, count_a3},  {13'b0, count_b3},  response3);
        if (done64) check_out(2, sel_a64, sel_b64, {13'b0, count_a64}, {13'b0, count_b64}, response64);
    end

    task automatic run_main(input logic [5:0] ch, input int unsigned ea, input int unsigned eb,
                            input logic er, input string nm);
        exp_t e;
        @(negedge clk);
        challenge = ch;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        e.nm   = nm;
        e.sa   = ch[2:0];
        e.sb   = ch[5:3];
        e.ca   = ea;
        e.cb   = eb;
        e.resp = er;
        e.acc  = cyc;
        e.lat  = S + W + 2;
        q0.push_back(e);
        chk({nm, "/busy_after_accept"}, 64'(busy), 64'(1));
        chk({nm, "/sel_after_accept"},  64'({sel_b, sel_a}), 64'(ch));
        chk({nm, "/counts_cleared"},    64'({count_a, count_b, response}), 64'(0));
    endtask

    task automatic wait_done(input int k, input int unsigned maxc, input string nm);
        bit seen = 1'b0;
        for (int unsigned i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            seen = (k == 0) ? done : (k == 1) ? done3 : done64;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s/timeout: got no done in %0d cycles, required done", nm, maxc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run, required finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   busy_ok;
        int unsigned ndone;

        rst = 1'b1; rst_s = 1'b1;
        start = 1'b0; start_s = 1'b0;
        challenge = '0; challenge_s = '0;
        repeat (3) @(negedge clk);
        chk("reset/outputs", 64'({busy, done, response, sel_a, sel_b, count_a, count_b}), 64'(0));
        rst = 1'b0; rst_s = 1'b0;

        // 1: basic compare, A period 4 -> 4 edges, B period 8 -> 2 edges
        per_a = 4; per_b = 8;
        run_main(6'b010_001, 4, 2, 1'b1, "basic");
        wait_done(0, 40, "basic");

        // 2: tie, identical waveforms
        per_b = 4;
        run_main(6'b101_011, 4, 4, 1'b0, "tie");
        wait_done(0, 40, "tie");

        // 3: saturation with 3-bit counters, 16 and 64 cycle windows
        repeat (2) @(negedge clk);
        challenge_s = 6'b000_111;
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        e.sa = 3'd7; e.sb = 3'd0; e.cb = 0; e.resp = 1'b1; e.acc = cyc;
        e.nm = "sat16"; e.ca = 4; e.lat = S + 16 + 2; q1.push_back(e);
        e.nm = "sat64"; e.ca = 7; e.lat = S + 64 + 2; q2.push_back(e);
        wait_done(2, 100, "sat64");

        // 4: start pulses while busy are ignored
        per_a = 4; per_b = 8;
        run_main(6'b010_001, 4, 2, 1'b1, "busy_start");
        busy_ok = 1'b1;
        for (int unsigned i = 0; i < S + W + 1; i++) begin
            @(negedge clk);
            if (i == 5 || i == 15) begin
                challenge = 6'b111_110;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0;
        chk("busy_start/busy_held", 64'(busy_ok), 64'(1));
        wait_done(0, 10, "busy_start");
        repeat (30) @(negedge clk);

        // 5: reset during COUNT aborts without done
        run_main(6'b001_110, 4, 2, 1'b1, "rst_abort");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_abort/outputs", 64'({busy, done, response, sel_a, sel_b, count_a, count_b}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        ndone = 0;
        for (int unsigned i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_abort/no_done", 64'(ndone), 64'(0));
        run_main(6'b010_001, 4, 2, 1'b1, "after_rst");
        wait_done(0, 40, "after_rst");

        // 6: back-to-back runs with oscillator speeds swapped
        run_main(6'b011_100, 4, 2, 1'b1, "b2b_1");
        wait_done(0, 40, "b2b_1");
        per_a = 8; per_b = 4;
        run_main(6'b100_011, 2, 4, 1'b0, "b2b_2");
        wait_done(0, 40, "b2b_2");

        repeat (5) @(negedge clk);
        chk("scoreboard/empty", 64'(q0.size() + q1.size() + q2.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
